// File: rtl/bound_flasher_pkg.sv
// Shared bound-flasher constants and the lamp-position type.
package bound_flasher_pkg;

    localparam int COUNTER_W    = 5;
    localparam int MAX_COUNT    = 16;
    localparam int KICK_POINT_A = 5;
    localparam int KICK_POINT_B = 10;

    typedef logic [COUNTER_W-1:0] lamp_pos_t;

endpackage

// File: rtl/kick_point_cmp.sv
// Combinational comparator: true when counter equals one kickback point and lies in the legal range.
module kick_point_cmp #(
    parameter int COUNTER_W  = 5,
    parameter int MAX_COUNT  = 16,
    parameter int KICK_POINT = 5
) (
    input  logic [COUNTER_W-1:0] counter,
    output logic                 hit
);

    localparam logic [COUNTER_W-1:0] KICK_VAL  = COUNTER_W'(KICK_POINT);
    localparam logic [COUNTER_W-1:0] MAX_VAL   = COUNTER_W'(MAX_COUNT);

    assign hit = (counter == KICK_VAL) && (counter <= MAX_VAL);

endmodule

// File: rtl/kickback_match_generator.sv
// Registered kickback-point detector for the bound flasher: flags the two kickback
// positions while a flick is requested.
module kickback_match_generator
    import bound_flasher_pkg::*;
#(
    parameter int COUNTER_W    = bound_flasher_pkg::COUNTER_W,
    parameter int MAX_COUNT    = bound_flasher_pkg::MAX_COUNT,
    parameter int KICK_POINT_A = bound_flasher_pkg::KICK_POINT_A,
    parameter int KICK_POINT_B = bound_flasher_pkg::KICK_POINT_B
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flick,
    input  logic [COUNTER_W-1:0] counter,
    output logic                 kickback_match
);

    if (KICK_POINT_A == KICK_POINT_B) begin : g_chk_distinct
        $error("kickback_match_generator: KICK_POINT_A and KICK_POINT_B must differ");
    end
    if (KICK_POINT_A > MAX_COUNT || KICK_POINT_B > MAX_COUNT) begin : g_chk_range
        $error("kickback_match_generator: kickback points must not exceed MAX_COUNT");
    end
    if (MAX_COUNT >= (1 << COUNTER_W)) begin : g_chk_width
        $error("kickback_match_generator: MAX_COUNT must fit in COUNTER_W bits");
    end

    logic hit_a_p0;
    logic hit_b_p0;
    logic hit_p0;

    kick_point_cmp #(
        .COUNTER_W  (COUNTER_W),
        .MAX_COUNT  (MAX_COUNT),
        .KICK_POINT (KICK_POINT_A)
    ) u_cmp_a (
        .counter (counter),
        .hit     (hit_a_p0)
    );

    kick_point_cmp #(
        .COUNTER_W  (COUNTER_W),
        .MAX_COUNT  (MAX_COUNT),
        .KICK_POINT (KICK_POINT_B)
    ) u_cmp_b (
        .counter (counter),
        .hit     (hit_b_p0)
    );

    assign hit_p0 = flick && (hit_a_p0 || hit_b_p0);

    // p0 -> output register: one-cycle latency, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kickback_match <= 1'b0;
        end else begin
            kickback_match <= hit_p0;
        end
    end

endmodule

// File: tb/tb_kickback_match_generator.sv
// Directed self-checking bench for kickback_match_generator.
module tb_kickback_match_generator;

    logic       clk;
    logic       rst;
    logic       flick;
    logic [4:0] counter;
    logic       kickback_match;

    int checks;
    int errors;

    kickback_match_generator #(
        .COUNTER_W    (5),
        .MAX_COUNT    (16),
        .KICK_POINT_A (5),
        .KICK_POINT_B (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flick          (flick),
        .counter        (counter),
        .kickback_match (kickback_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Apply inputs on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input logic f, input logic [4:0] c);
        @(negedge clk);
        flick   = f;
        counter = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        flick   = 1'b1;
        counter = 5'd5;

        // Reset held with a matching input: output must stay 0.
        #1;
        check("reset_immediate", kickback_match, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", kickback_match, 1'b0);
        end

        // Release reset; first edge samples the hit.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", kickback_match, 1'b1);

        // Idle flick: never a match.
        for (int c = 0; c < 32; c++) begin
            step(1'b0, 5'(c));
            check($sformatf("idle_c%0d", c), kickback_match, 1'b0);
        end

        // Flick sweep: match only at 5 and 10.
        for (int c = 0; c < 32; c++) begin
            step(1'b1, 5'(c));
            check($sformatf("sweep_c%0d", c), kickback_match, (c == 5 || c == 10) ? 1'b1 : 1'b0);
        end

        // One-cycle flick pulse at counter 10.
        step(1'b0, 5'd10);
        check("pulse_pre", kickback_match, 1'b0);
        step(1'b1, 5'd10);
        check("pulse_hi", kickback_match, 1'b1);
        step(1'b0, 5'd10);
        check("pulse_lo", kickback_match, 1'b0);
        step(1'b0, 5'd10);
        check("pulse_after", kickback_match, 1'b0);

        // Simultaneous counter/flick change.
        step(1'b0, 5'd4);
        check("simul_pre", kickback_match, 1'b0);
        step(1'b1, 5'd5);
        check("simul_on", kickback_match, 1'b1);
        step(1'b1, 5'd6);
        check("simul_off", kickback_match, 1'b0);

        // Asynchronous reset between edges while matching.
        step(1'b1, 5'd5);
        check("async_pre", kickback_match, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_drop", kickback_match, 1'b0);
        @(posedge clk);
        #1;
        check("async_held", kickback_match, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("async_release", kickback_match, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
